// File: rtl/morse_pkg.sv
// Shared Morse definitions: symbol codes for the letter decoder, sequencer state
// encoding and the unit multipliers that set the dit/dah, gap and space thresholds.
package morse_pkg;

   typedef enum logic [2:0] {
      SymWait  = 3'd0,
      SymDit   = 3'd1,
      SymDah   = 3'd2,
      SymGap   = 3'd3,
      SymSpace = 3'd4
   } symbol_e;

   typedef enum logic [1:0] {
      StIdle,
      StMark,
      StIntra,
      StWord
   } seq_state_e;

   localparam int unsigned DahMult   = 2;
   localparam int unsigned GapMult   = 2;
   localparam int unsigned SpaceMult = 5;

   function automatic int unsigned units_to_cycles(input int unsigned units,
                                                   input int unsigned unit_cycles);
      return units * unit_cycles;
   endfunction

endpackage

// File: rtl/morse_key_debounce.sv
// Two-flop synchronizer for the raw key, followed by a stable-count filter when
// MORSE_KEY_DEBOUNCE_EN is defined.
module morse_key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_in,
   output logic key_out
);

   logic [1:0] sync_q;

   if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be >= 1");
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], key_in};
      end
   end

`ifdef MORSE_KEY_DEBOUNCE_EN
   localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);

   logic           key_q, key_d;
   logic [DbW-1:0] db_cnt_q, db_cnt_d;

   // Count consecutive cycles the synchronized level disagrees with the filtered one.
   always_comb begin
      key_d    = key_q;
      db_cnt_d = '0;
      if (sync_q[1] != key_q) begin
         if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
            key_d = sync_q[1];
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q    <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         key_q    <= key_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   assign key_out = key_q;
`else
   assign key_out = sync_q[1];
`endif

endmodule

// File: rtl/morse_key_sequencer.sv
// Times Morse key marks and spaces in dot units and emits one-cycle WAIT/DIT/DAH/GAP/SPACE
// symbols. Optional key debouncing is enabled with the MORSE_KEY_DEBOUNCE_EN macro.
module morse_key_sequencer
   import morse_pkg::*;
#(
   parameter int unsigned UNIT_CYCLES     = 1000,
   parameter int unsigned CNT_W           = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_in,
   input  logic       enable,
   output logic [2:0] symbol,
   output logic       symbol_valid,
   output logic       busy
);

   localparam logic [CNT_W-1:0] DahCnt   = CNT_W'(units_to_cycles(DahMult, UNIT_CYCLES));
   localparam logic [CNT_W-1:0] GapCnt   = CNT_W'(units_to_cycles(GapMult, UNIT_CYCLES));
   localparam logic [CNT_W-1:0] SpaceCnt = CNT_W'(units_to_cycles(SpaceMult, UNIT_CYCLES));
   localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

   if (UNIT_CYCLES < 2) begin : g_bad_unit
      $error("UNIT_CYCLES must be >= 2");
   end

   logic             key;
   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   symbol_e          symbol_q, symbol_d;

   morse_key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_in  (key_in),
      .key_out (key)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      symbol_d = SymWait;
      if (!enable) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (key) begin
                  state_d = StMark;
                  cnt_d   = CntOne;
               end
            end
            StMark: begin
               if (key) begin
                  if (cnt_q != '1) begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end else begin
                  symbol_d = (cnt_q < DahCnt) ? SymDit : SymDah;
                  state_d  = StIntra;
                  cnt_d    = CntOne;
               end
            end
            StIntra: begin
               if (cnt_q == GapCnt) begin
                  symbol_d = SymGap;
                  state_d  = StWord;
               end
               // A press on the threshold cycle still lets the GAP out.
               if (key) begin
                  state_d = StMark;
                  cnt_d   = CntOne;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StWord: begin
               if (key) begin
                  state_d = StMark;
                  cnt_d   = CntOne;
               end else if (cnt_q == SpaceCnt) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
               if (cnt_q == SpaceCnt) begin
                  symbol_d = SymSpace;
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         symbol_q <= SymWait;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         symbol_q <= symbol_d;
      end
   end

   assign symbol       = symbol_q;
   assign symbol_valid = (symbol_q != SymWait);
   assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Directed bench for morse_key_sequencer with UNIT_CYCLES=4 (dah/gap at 8, space at 20).
module tb_morse_key_sequencer;

   localparam int SymWait  = 0;
   localparam int SymDit   = 1;
   localparam int SymDah   = 2;
   localparam int SymGap   = 3;
   localparam int SymSpace = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       key_in;
   logic       enable;
   logic [2:0] symbol;
   logic       symbol_valid;
   logic       busy;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int ev_cyc[$];
   int ev_sym[$];

   morse_key_sequencer #(
      .UNIT_CYCLES     (4),
      .CNT_W           (5),
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_in       (key_in),
      .enable       (enable),
      .symbol       (symbol),
      .symbol_valid (symbol_valid),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance n cycles, sampling 1 time unit after each edge and logging every pulse.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         n_checks++;
         assert (symbol_valid === (symbol != 3'd0)) else begin
            n_err++;
            $error("FAIL valid_vs_symbol: observed valid=%b symbol=%0d at cycle %0d",
                   symbol_valid, symbol, cyc);
         end
         if (symbol_valid === 1'b1) begin
            ev_cyc.push_back(cyc);
            ev_sym.push_back(int'(symbol));
         end
      end
   endtask

   task automatic clear_ev();
      ev_cyc.delete();
      ev_sym.delete();
   endtask

   task automatic press(input int n);
      key_in = 1'b1;
      step(n);
      key_in = 1'b0;
   endtask

   task automatic chk_ev(input string tag, input int idx, input int exp_sym, input int exp_cyc);
      int obs_sym;
      int obs_cyc;
      obs_sym = (idx < ev_sym.size()) ? ev_sym[idx] : -1;
      obs_cyc = (idx < ev_cyc.size()) ? ev_cyc[idx] : -1;
      chk({tag, "_sym"}, obs_sym, exp_sym);
      chk({tag, "_cyc"}, obs_cyc, exp_cyc);
   endtask

   initial begin
      int c;
      int e;
      int lens[3];
      int syms[3];
      lens = '{12, 8, 7};
      syms = '{SymDah, SymDah, SymDit};

      rst_n  = 1'b0;
      key_in = 1'b0;
      enable = 1'b1;
      step(3);
      chk("reset_symbol", int'(symbol), SymWait);
      chk("reset_valid", int'(symbol_valid), 0);
      chk("reset_busy", int'(busy), 0);
      rst_n = 1'b1;
      step(2);
      chk("idle_busy", int'(busy), 0);

`ifdef MORSE_KEY_DEBOUNCE_EN
      // 5-cycle glitch is filtered out entirely
      clear_ev();
      press(5);
      step(30);
      chk("glitch_count", ev_sym.size(), 0);
      chk("glitch_busy", int'(busy), 0);

      // 20-cycle press: DAH 8 cycles later than without the filter
      clear_ev();
      c = cyc;
      press(20);
      step(45);
      chk_ev("db_dah", 0, SymDah, c + 31);
      chk_ev("db_gap", 1, SymGap, c + 39);
      chk_ev("db_space", 2, SymSpace, c + 51);
      chk("db_count", ev_sym.size(), 3);
`else
      // Short press then long silence: DIT, GAP, SPACE
      clear_ev();
      c = cyc;
      press(3);
      step(10);
      chk("dit_busy_mid", int'(busy), 1);
      step(30);
      chk_ev("t1_dit", 0, SymDit, c + 6);
      chk_ev("t3_gap", 1, SymGap, c + 14);
      chk_ev("t3_space", 2, SymSpace, c + 26);
      chk("t3_count", ev_sym.size(), 3);
      chk("t3_busy_end", int'(busy), 0);

      // Dit/dah threshold
      for (int i = 0; i < 3; i++) begin
         clear_ev();
         c = cyc;
         press(lens[i]);
         step(30);
         chk_ev($sformatf("t2_len%0d", lens[i]), 0, syms[i], c + lens[i] + 3);
         chk($sformatf("t2_len%0d_count", lens[i]), ev_sym.size(), 3);
      end

      // Re-press 5 cycles after release: no GAP in between
      clear_ev();
      c = cyc;
      press(3);
      step(5);
      press(3);
      step(30);
      chk_ev("t4a_dit0", 0, SymDit, c + 6);
      chk_ev("t4a_dit1", 1, SymDit, c + 14);
      chk("t4a_count", ev_sym.size(), 4);

      // Re-press landing exactly on the GAP decision
      clear_ev();
      c = cyc;
      press(3);
      step(8);
      press(9);
      step(30);
      chk_ev("t4b_dit", 0, SymDit, c + 6);
      chk_ev("t4b_gap", 1, SymGap, c + 14);
      chk_ev("t4b_dah", 2, SymDah, c + 23);
      chk_ev("t4b_gap2", 3, SymGap, c + 31);
      chk_ev("t4b_space", 4, SymSpace, c + 43);
      chk("t4b_count", ev_sym.size(), 5);

      // Reset mid-mark with key held, then a 2-cycle hold after release
      clear_ev();
      key_in = 1'b1;
      step(8);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_symbol", int'(symbol), SymWait);
      chk("t5_rst_busy", int'(busy), 0);
      step(2);
      chk("t5_rst_symbol2", int'(symbol), SymWait);
      rst_n = 1'b1;
      step(2);
      key_in = 1'b0;
      e = cyc;
      step(30);
      chk_ev("t5_dit", 0, SymDit, e + 3);
      chk("t5_count", ev_sym.size(), 3);

      // enable=0 discards the mark; re-enabling with key held starts a fresh one
      clear_ev();
      key_in = 1'b1;
      step(10);
      enable = 1'b0;
      step(1);
      chk("en_symbol", int'(symbol), SymWait);
      chk("en_busy", int'(busy), 0);
      step(1);
      enable = 1'b1;
      step(2);
      key_in = 1'b0;
      e = cyc;
      step(30);
      chk_ev("en_dit", 0, SymDit, e + 3);
      chk("en_count", ev_sym.size(), 3);

      // 35-cycle press saturates the 5-bit counter and must still be a DAH
      clear_ev();
      c = cyc;
      press(35);
      step(30);
      chk_ev("sat_dah", 0, SymDah, c + 38);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
